// File: rtl/div_unit.sv
// div_unit: multicycle signed 32-bit radix-2 restoring divider.
// Produces the quotient on lo and the remainder on hi through a start/done
// handshake. A zero divisor raises div0 together with done and leaves
// hi/lo untouched.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // The partial remainder never exceeds |divisor| <= 2^31, so 32 stored bits
  // are enough; the 33-bit view exists only for the shifted compare/subtract.
  logic [31:0] r_rem;
  logic [31:0] r_q;
  logic [31:0] r_dvs;
  logic        r_sign_q;
  logic        r_sign_r;
  logic [5:0]  r_cnt;
  logic        r_done;
  logic        r_div0;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_q_nxt;

  // Two's-complement negation truncated to 32 bits.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a signed operand; 0x80000000 maps to itself as unsigned.
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode: 32 RUN cycles, one FIX cycle, one DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (divisor == 32'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == 6'd31) w_next = S_FIX;
      end
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One restoring iteration: shift in the next dividend bit, trial-subtract.
  always_comb begin
    w_rem_sh  = {r_rem, r_q[31]};
    w_diff    = w_rem_sh - {1'b0, r_dvs};
    w_ge      = ~w_diff[32];
    w_rem_nxt = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    w_q_nxt   = {r_q[30:0], w_ge};
  end

  // Operand latch, iteration, sign fix-up and the registered done/div0 pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= '0;
      r_q      <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q      <= abs32(dividend);
            r_dvs    <= abs32(divisor);
            r_sign_q <= dividend[31] ^ divisor[31];
            r_sign_r <= dividend[31];
            r_rem    <= '0;
            r_cnt    <= '0;
            if (divisor == 32'd0) begin
              r_done <= 1'b1;
              r_div0 <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          r_lo   <= r_sign_q ? neg32(r_q) : r_q;
          r_hi   <= r_sign_r ? neg32(r_rem) : r_rem;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign div0 = r_div0;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
